pe_cfg_streamer: RTL

// - Upstream config source for the PE array: holds a small table of config words and, on start,

---
 rtl/pe_cfg_streamer_pkg.sv | 21 ++
 rtl/pe_cfg_streamer_table.sv | 29 ++
 rtl/pe_cfg_streamer.sv | 121 ++++++++++++
 3 files changed

// File: rtl/pe_cfg_streamer_pkg.sv
// pe_cfg_streamer_pkg: shared widths, FSM state and config-beat layout for the PE config streamer.
package pe_cfg_streamer_pkg;

    localparam int CFG_W         = 33;
    localparam int CFG_VALID_BIT = 32;

    typedef enum logic {
        IDLE,
        STREAM
    } state_t;

    typedef struct packed {
        logic        valid;
        logic [31:0] payload;
    } cfg_beat_t;

    function automatic cfg_beat_t mk_beat(input logic [31:0] payload);
        return '{valid: 1'b1, payload: payload};
    endfunction

endpackage

// File: rtl/pe_cfg_streamer_table.sv
// pe_cfg_table: config word table, one synchronous write port and one asynchronous read port.
//   clk      : write clock
//   wr_en    : write strobe (already qualified by the caller)
//   wr_addr  : write address
//   wr_data  : entry {pe_sel, payload}
//   rd_addr  : read address
//   rd_data  : entry at rd_addr, combinational
// Contents are deliberately not reset so a table survives a streamer reset.
module pe_cfg_table #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4,
    parameter int W      = 33
) (
    input  logic              clk,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [W-1:0]      wr_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [W-1:0]      rd_data
);

    logic [W-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (wr_en) mem[wr_addr] <= wr_data;

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/pe_cfg_streamer.sv
// pe_cfg_streamer: streams a table of config words, one per cycle, onto per-PE 33-bit config ports.
//   clk, reset  : clock, synchronous active-high reset
//   tbl_wr_*    : table write port, honoured only while idle
//   tbl_len     : number of entries to stream, latched on start
//   start       : begin a stream (ignored while streaming)
//   abort       : stop immediately, no done
//   cfg_out     : NUM_PE ports of {valid, payload}, port p at cfg_out[p*33 +: 33]
//   busy        : a stream slot is being driven this cycle
//   done        : pulses with the last beat (or alone for a zero-length stream)
//   sel_err     : sticky, an entry targeted a non-existent PE
module pe_cfg_streamer
    import pe_cfg_streamer_pkg::*;
#(
    parameter int NUM_PE   = 2,
    parameter int DEPTH    = 16,
    parameter int PE_SEL_W = 1,
    parameter int ADDR_W   = 4
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    tbl_wr_en,
    input  logic [ADDR_W-1:0]       tbl_wr_addr,
    input  logic [PE_SEL_W+31:0]    tbl_wr_data,
    input  logic [ADDR_W:0]         tbl_len,
    input  logic                    start,
    input  logic                    abort,
    output logic [NUM_PE*CFG_W-1:0] cfg_out,
    output logic                    busy,
    output logic                    done,
    output logic                    sel_err
);

    localparam int                EW       = PE_SEL_W + 32;
    localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
    localparam logic [ADDR_W:0]   LEN_ONE  = 1;

    state_t                    state, state_n;
    logic [ADDR_W-1:0]         addr, addr_n;
    logic [ADDR_W:0]           len, len_n;
    logic [NUM_PE*CFG_W-1:0]   cfg_n;
    logic                      busy_n, done_n, sel_err_n;
    logic [EW-1:0]             entry;
    logic [PE_SEL_W-1:0]       sel;
    cfg_beat_t                 beat;
    logic                      sel_ok, last, wr_ok;

    // busy is also checked so the table stays frozen while the final beat is still on the ports
    assign wr_ok = tbl_wr_en && state == IDLE && !busy && !abort;

    pe_cfg_table #(
        .DEPTH  (DEPTH),
        .ADDR_W (ADDR_W),
        .W      (EW)
    ) u_table (
        .clk     (clk),
        .wr_en   (wr_ok),
        .wr_addr (tbl_wr_addr),
        .wr_data (tbl_wr_data),
        .rd_addr (addr),
        .rd_data (entry)
    );

    assign sel    = entry[CFG_VALID_BIT +: PE_SEL_W];
    assign beat   = mk_beat(entry[CFG_VALID_BIT-1:0]);
    assign sel_ok = int'(sel) < NUM_PE;
    // compared one bit wider than addr so a full-depth stream ends as addr wraps to 0
    assign last   = len == {1'b0, addr} + LEN_ONE;

    always_comb begin
        state_n   = state;
        addr_n    = addr;
        len_n     = len;
        cfg_n     = '0;
        busy_n    = 1'b0;
        done_n    = 1'b0;
        sel_err_n = sel_err;
        if (abort) begin
            state_n = IDLE;
        end else if (state == IDLE) begin
            if (start) begin
                state_n = STREAM;
                addr_n  = '0;
                len_n   = tbl_len;
            end
        end else if (len == '0) begin
            // zero-length stream: one cycle in STREAM just to produce the done pulse
            state_n = IDLE;
            done_n  = 1'b1;
        end else begin
            busy_n    = 1'b1;
            done_n    = last;
            addr_n    = addr + ADDR_ONE;
            state_n   = last ? IDLE : STREAM;
            sel_err_n = sel_err | !sel_ok;
            // bad pe_sel matches no port, so the slot goes out as all zeros
            for (int p = 0; p < NUM_PE; p++)
                cfg_n[p*CFG_W +: CFG_W] = {CFG_W{sel_ok && int'(sel) == p}} & beat;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            addr    <= '0;
            len     <= '0;
            cfg_out <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            sel_err <= 1'b0;
        end else begin
            state   <= state_n;
            addr    <= addr_n;
            len     <= len_n;
            cfg_out <= cfg_n;
            busy    <= busy_n;
            done    <= done_n;
            sel_err <= sel_err_n;
        end
    end

endmodule
